// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared loader state, word geometry and defaults
package imem_boot_loader_pkg;
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;
    localparam int WORD_BYTES = 4;
    localparam int DEF_MAX_WORDS = 64;
    localparam logic [31:0] DEF_ADDR_BASE = 32'h0000_0000;
endpackage

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// imem_boot_loader_byte_word_assembler: MSB-first byte to 32-bit word packer
module imem_boot_loader_byte_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        strobe,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [23:0] sh_q, sh_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;

    always_comb begin
        sh_d    = strobe ? {sh_q[15:0], byte_in} : sh_q;
        idx_d   = clr ? 2'd0 : strobe ? idx_q + 2'd1 : idx_q;
        valid_d = !clr && strobe && idx_q == 2'd3;
        word_d  = valid_d ? {sh_q, byte_in} : word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign byte_idx   = idx_q;
    assign word_valid = valid_q;
    assign word       = word_q;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream program loader feeding instruction memory
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          MAX_WORDS = DEF_MAX_WORDS,
    parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE
) (
    input  logic        clock,
    input  logic        reset_global,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d, chk_q, chk_d;
    logic [15:0] n_q, n_d, wl_q, wl_d, n_in;
    logic [31:0] addr_q, addr_d;
    logic        done_q, done_d, error_q, error_d;
    logic        cpu_reset_q, cpu_reset_d, in_ready_q, in_ready_d;
    logic        xfer, strobe, reload_ok;
    logic [1:0]  byte_idx;

    assign xfer      = in_valid && in_ready_q;
    assign strobe    = xfer && state_q == S_DATA;
    assign reload_ok = reload && (state_q == S_DONE || state_q == S_ERROR);
    assign n_in      = {len_hi_q, in_data};

    imem_boot_loader_byte_word_assembler u_asm (
        .clk        (clock),
        .rst        (reset_global),
        .clr        (reload_ok),
        .byte_in    (in_data),
        .strobe     (strobe),
        .byte_idx   (byte_idx),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        chk_d    = chk_q;
        n_d      = n_q;
        wl_d     = wl_q;
        addr_d   = addr_q;
        if (reload_ok) begin
            state_d = S_LEN_HI;
            chk_d   = '0;
            wl_d    = '0;
        end else if (xfer) begin
            case (state_q)
                S_LEN_HI: begin
                    len_hi_d = in_data;
                    chk_d    = chk_q ^ in_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    chk_d   = chk_q ^ in_data;
                    n_d     = n_in;
                    state_d = n_in > 16'(MAX_WORDS) ? S_ERROR : n_in == 16'd0 ? S_CHECK : S_DATA;
                end
                S_DATA: begin
                    chk_d = chk_q ^ in_data;
                    if (byte_idx == 2'd3) begin
                        wl_d    = wl_q + 16'd1;
                        addr_d  = ADDR_BASE + 32'(wl_q) * 32'(WORD_BYTES);
                        state_d = wl_d == n_q ? S_CHECK : S_DATA;
                    end
                end
                S_CHECK: state_d = in_data == chk_q ? S_DONE : S_ERROR;
                default: state_d = state_q;
            endcase
        end
        done_d      = state_d == S_DONE;
        error_d     = state_d == S_ERROR;
        cpu_reset_d = state_d != S_DONE;
        in_ready_d  = !(done_d || error_d);
    end

    always_ff @(posedge clock) begin
        if (reset_global) begin
            state_q     <= S_LEN_HI;
            len_hi_q    <= '0;
            chk_q       <= '0;
            n_q         <= '0;
            wl_q        <= '0;
            addr_q      <= ADDR_BASE;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            chk_q       <= chk_d;
            n_q         <= n_d;
            wl_q        <= wl_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_addr    = addr_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed frame vectors against hand-computed results
module tb_imem_boot_loader;
    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset_global = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_reset, done, error;
    logic [15:0] words_loaded;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int base;
    bq_t f;

    imem_boot_loader dut (
        .clock        (clock),
        .reset_global (reset_global),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_we) begin
            we_addr.push_back(imem_addr);
            we_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_seq(input bq_t b, input int max_gap);
        foreach (b[i]) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clock);
            #1;
            send(b[i]);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clock);
        check({tag, "_rdy"}, in_ready, 1);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_wdata"}, imem_wdata, 32'h0);
        check({tag, "_cpurst"}, cpu_reset, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_wl"}, words_loaded, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        check_reset_vals("rst");
        @(posedge clock);
        #1;
        reset_global = 1'b0;

        f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        base = we_addr.size();
        send_seq(f, 0);
        @(negedge clock);
        check("a_done", done, 1);
        check("a_cpurst", cpu_reset, 0);
        check("a_rdy", in_ready, 0);
        check("a_wl", words_loaded, 1);
        check("a_wecnt", we_addr.size() - base, 1);
        check("a_addr", we_addr[base], 32'h0);
        check("a_data", we_data[base], 32'h2008_0005);

        pulse_reload();
        @(negedge clock);
        check("rl_cpurst", cpu_reset, 1);
        check("rl_done", done, 0);
        check("rl_wl", words_loaded, 0);
        check("rl_rdy", in_ready, 1);

        f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        base = we_addr.size();
        send_seq(f, 0);
        @(negedge clock);
        check("b_err", error, 1);
        check("b_done", done, 0);
        check("b_cpurst", cpu_reset, 1);
        check("b_rdy", in_ready, 0);
        check("b_wecnt", we_addr.size() - base, 1);

        pulse_reload();
        f = '{8'h00, 8'h41};
        base = we_addr.size();
        send_seq(f, 0);
        @(negedge clock);
        check("c_err", error, 1);
        check("c_rdy", in_ready, 0);
        repeat (3) @(posedge clock);
        check("c_wecnt", we_addr.size() - base, 0);

        pulse_reload();
        f = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'h00, 8'h00, 8'h00, 8'h13, 8'h76};
        base = we_addr.size();
        send_seq(f, 3);
        @(negedge clock);
        check("d_done", done, 1);
        check("d_wl", words_loaded, 3);
        check("d_wecnt", we_addr.size() - base, 3);
        if (we_addr.size() - base == 3) begin
            check("d_addr0", we_addr[base], 32'h0);
            check("d_addr1", we_addr[base+1], 32'h4);
            check("d_addr2", we_addr[base+2], 32'h8);
            check("d_data0", we_data[base], 32'h1122_3344);
            check("d_data1", we_data[base+1], 32'hDEAD_BEEF);
            check("d_data2", we_data[base+2], 32'h0000_0013);
        end

        pulse_reload();
        f = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        base = we_addr.size();
        send_seq(f, 0);
        reset_global = 1'b1;
        @(posedge clock);
        #1;
        reset_global = 1'b0;
        check_reset_vals("mid");
        check("mid_wecnt", we_addr.size() - base, 0);
        f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        send_seq(f, 1);
        @(negedge clock);
        check("e_done", done, 1);
        check("e_wecnt", we_addr.size() - base, 1);
        check("e_addr", we_addr[base], 32'h0);
        check("e_data", we_data[base], 32'h2008_0005);

        pulse_reload();
        @(negedge clock);
        check("f_cpurst", cpu_reset, 1);
        f = '{8'h00, 8'h00, 8'h00};
        base = we_addr.size();
        send_seq(f, 0);
        @(negedge clock);
        check("f_done", done, 1);
        check("f_cpurst2", cpu_reset, 0);
        check("f_wl", words_loaded, 0);
        check("f_wecnt", we_addr.size() - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader sitting directly upstream of the instruction memory and processor core.
- Receives a framed program image (length, big-endian instruction words, checksum) over a valid/ready byte interface.
- Writes each assembled word into instruction memory, then releases the core from reset.
- Holds the core in reset while loading and after any framing or checksum error.

Parameters:
MAX_WORDS, 64, largest accepted program length in 32-bit words (1..65535)
ADDR_BASE, 32'h0000_0000, byte address of the first instruction written

Ports:
clock  input  1  system clock, all logic on rising edge
reset_global  input  1  synchronous active-high reset
in_data  input  8  incoming image byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready
reload  input  1  single-cycle request to start a new load from DONE or ERROR
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  32  byte address of the word being written
imem_wdata  output  32  instruction word being written
cpu_reset  output  1  reset to the core (drives the PC/regfile reset)
done  output  1  image loaded and verified
error  output  1  length or checksum fault, sticky until reload/reset
words_loaded  output  16  count of words written in the current load

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset_global).
- Reset values: state=LEN_HI, in_ready=1, imem_we=0, imem_addr=ADDR_BASE, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0, checksum accumulator=0.
- Priority: reset_global overrides all inputs. reset_global mid-load aborts the load, and partially written memory is left as is.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (MSB first per word), then CHK.
- CHK equals the XOR of every preceding byte of the frame.
- State LEN_HI, on transfer: latch the high byte, fold it into the checksum, go to LEN_LO.
- State LEN_LO, on transfer: form N.
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CHECK.
  - Otherwise: go to DATA with byte_idx=0.
- State DATA, on transfer: shift the byte into the word register and fold it into the checksum; byte_idx increments mod 4.
  - On the 4th byte: the next cycle has imem_we=1, imem_wdata=word, imem_addr=ADDR_BASE+4*words_loaded (pre-increment value); words_loaded increments in that same cycle.
  - After word N is written, go to CHECK.
- State CHECK, on transfer: compare the byte to the accumulator. Match: go to DONE. Mismatch: go to ERROR. Both outputs update the cycle after the transfer.
- State DONE: done=1, cpu_reset=0, in_ready=0.
- State ERROR: error=1, cpu_reset=1, in_ready=0.
- reload in DONE or ERROR: next cycle go to LEN_HI and clear done, error, words_loaded and the accumulator. cpu_reset=1 from that cycle onward. reload is ignored in every other state.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CHECK. There is no internal backpressure; idle cycles (in_valid=0) are allowed anywhere in a frame.
- imem_we is never asserted outside DATA-completion cycles, and is never asserted for an aborted partial word.
- Address arithmetic is 32-bit and wraps modulo 2^32 (unreachable for a legal MAX_WORDS).

Decomposition:
- Shared package holds:
  - loader state enum (LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR);
  - constant WORD_BYTES=4;
  - default MAX_WORDS and ADDR_BASE.
- One natural sub-module: byte_word_assembler. It takes the byte plus a strobe, shifts in MSB-first, and emits word_valid and the 32-bit word after 4 bytes. It has a clear input to discard a partial word.

Test Plan:
- Frame 00 01 20 08 00 05 2C -> one imem_we with addr 0x0, wdata 0x20080005; done=1; cpu_reset=0; words_loaded=1.
- Frame 00 01 20 08 00 05 2D -> imem_we pulses once; CHK mismatch gives error=1, done=0, cpu_reset=1; in_ready=0.
- Frame with N=0x0041 (MAX_WORDS=64) -> ERROR right after LEN_LO; no imem_we; error=1.
- N=3 with random in_valid gaps -> exactly 3 imem_we pulses at 0x0, 0x4, 0x8; correct words; then done=1.
- reset_global asserted after 2 data bytes -> all outputs at reset values next cycle; a following valid 1-word frame writes addr 0x0 correctly.
- After done, pulse reload, then send frame 00 00 00 -> cpu_reset=1 during reload, then done=1 with words_loaded=0 and no imem_we.
